// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FAULT = 3'd5
    } pc_seq_state_t;

    localparam int INSTR_BYTES  = 4;
    localparam int MAX_WAIT_DEF = 15;
    localparam int WAIT_W       = $clog2(MAX_WAIT_DEF + 1);

endpackage

// File: rtl/fetch_timer.sv
// Response timeout timer: down-counter loaded on clear, terminal flag on the
// MAX_WAIT-th enabled cycle since the clear.
module fetch_timer
    import pc_seq_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int W        = WAIT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // The cycle of the clear's target state counts as the first waited cycle.
    localparam logic [W-1:0] LOAD = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests and holds the
// fetched instruction until the datapath consumes it.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   BOOT     | one idle cycle after reset
//   REQ      | imem_req asserted at pc, waiting for grant
//   WAIT     | granted, waiting for rvalid (timed)
//   HOLD     | instruction presented, waiting for consume
//   DRAIN    | discarding a response orphaned by a trap (timed)
//   FAULT    | fetch stopped; only trap or reset leaves
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              MAX_WAIT     = MAX_WAIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    output logic            fetch_fault,
    output logic [XLEN-1:0] pc
);

    pc_seq_state_t   state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] imem_addr_d, imem_addr_q;
    logic            imem_req_d, imem_req_q;
    logic            instr_valid_d, instr_valid_q;
    logic [31:0]     instr_d, instr_q;
    logic [XLEN-1:0] instr_pc_d, instr_pc_q;
    logic            fault_d, fault_q;
    logic            tmr_clr, tmr_en, tmr_tc;

    fetch_timer #(
        .MAX_WAIT (MAX_WAIT),
        .W        ($clog2(MAX_WAIT + 1))
    ) u_fetch_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;

        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end else if (tmr_tc) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = branch_taken ? branch_target : pc_q + XLEN'(INSTR_BYTES);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid || tmr_tc) state_d = ST_REQ;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase

        // A grant in the trap cycle still owes a response, so it must be drained.
        if (trap && (state_q != ST_BOOT)) begin
            pc_d          = TRAP_VECTOR;
            instr_valid_d = 1'b0;
            fault_d       = 1'b0;
            state_d       = ((state_q == ST_WAIT) || ((state_q == ST_REQ) && imem_gnt))
                            ? ST_DRAIN : ST_REQ;
        end

        imem_req_d  = (state_d == ST_REQ);
        imem_addr_d = imem_req_d ? pc_d : '0;
        tmr_clr     = (state_d != state_q);
        tmr_en      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the fetch/stall/branch
// flow, then hand-written sequences for timeout, trap and wrap corners.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        fetch_fault;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap          (trap),
        .fetch_fault   (fetch_fault),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt, rv, st, br, tr;
        logic [31:0] rdata, tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr, e_ipc;
        logic        e_fault;
        logic [31:0] e_pc;
    } vec_t;

    localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0010_0093, A2 = 32'h0020_0113;
    localparam logic [31:0] A3 = 32'h0030_0193, A4 = 32'h0040_0213, A5 = 32'h0050_0293;
    localparam logic [31:0] A6 = 32'h0060_0313, A7 = 32'h0070_0393, A8 = 32'h0080_0413;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    function automatic vec_t v(input logic g, rv, st, br, tr, input logic [31:0] rd, tg,
                               input logic er, input logic [31:0] ea, input logic eiv,
                               input logic [31:0] ei, eipc, input logic ef,
                               input logic [31:0] epc);
        vec_t r;
        r.gnt = g; r.rv = rv; r.st = st; r.br = br; r.tr = tr; r.rdata = rd; r.tgt = tg;
        r.e_req = er; r.e_addr = ea; r.e_iv = eiv; r.e_instr = ei; r.e_ipc = eipc;
        r.e_fault = ef; r.e_pc = epc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic g, rv, input logic [31:0] rd, input logic st, br,
                         input logic [31:0] tg, input logic tr);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        stall = st; branch_taken = br; branch_target = tg; trap = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; branch_taken = 0; branch_target = 0; trap = 0;

        //            g  rv st br tr rdata tgt          req addr iv instr ipc fault pc
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            1, 0,    0, 0,  0,   0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            0, 0,    0, 0,  0,   0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, A0,  0,            0, 0,    1, A0, 0,   0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            1, 4,    0, 0,  0,   0, 4));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            0, 0,    0, 0,  0,   0, 4));
        tbl.push_back(v(1, 1, 0, 0, 0, A1,  0,            0, 0,    1, A1, 4,   0, 4));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            1, 8,    0, 0,  0,   0, 8));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            0, 0,    0, 0,  0,   0, 8));
        tbl.push_back(v(1, 1, 0, 0, 0, A2,  0,            0, 0,    1, A2, 8,   0, 8));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, 1, 1, 0, 0, BAD, 0,        0, 0,    1, A2, 8,   0, 8));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,   0,            1, 12,   0, 0,  0,   0, 12));
        tbl.push_back(v(0, 1, 0, 0, 0, BAD, 0,            1, 12,   0, 0,  0,   0, 12));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            0, 0,    0, 0,  0,   0, 12));
        tbl.push_back(v(1, 1, 0, 0, 0, A3,  0,            0, 0,    1, A3, 12,  0, 12));
        tbl.push_back(v(0, 0, 0, 1, 0, 0,   32'h40,       1, 32'h40, 0, 0, 0,  0, 32'h40));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   0,            0, 0,    0, 0,  0,   0, 32'h40));
        tbl.push_back(v(1, 1, 0, 0, 0, A4,  0,            0, 0,    1, A4, 32'h40, 0, 32'h40));
        tbl.push_back(v(0, 0, 0, 1, 0, 0,   32'h42,       0, 0,    0, 0,  0,   1, 32'h40));
        tbl.push_back(v(1, 1, 0, 0, 0, BAD, 0,            0, 0,    0, 0,  0,   1, 32'h40));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_iv", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_pc", pc, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].tr);
            chk($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_iv", i), instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
                chk($sformatf("v%0d_ipc", i), instr_pc, tbl[i].e_ipc);
            end
            chk($sformatf("v%0d_fault", i), fetch_fault, tbl[i].e_fault);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
        end

        // Leave FAULT by trap, then time out a fetch.
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("trap1_fault", fetch_fault, 0);
        chk("trap1_req", imem_req, 1);
        chk("trap1_addr", imem_addr, 32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (14) idle();
        chk("to14_fault", fetch_fault, 0);
        chk("to14_req", imem_req, 0);
        idle();
        chk("to15_fault", fetch_fault, 1);
        chk("to15_req", imem_req, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("trap2_fault", fetch_fault, 0);
        chk("trap2_addr", imem_addr, 32'h100);

        // Trap while waiting: the late response must be dropped.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("drain_req", imem_req, 0);
        chk("drain_iv", instr_valid, 0);
        drive(0, 1, BAD, 0, 0, 0, 0);
        chk("drain_rv_iv", instr_valid, 0);
        chk("drain_rv_req", imem_req, 1);
        chk("drain_rv_addr", imem_addr, 32'h100);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("gnttrap_req", imem_req, 0);
        drive(0, 1, BAD, 0, 0, 0, 0);
        chk("gnttrap_iv", instr_valid, 0);
        chk("gnttrap_addr", imem_addr, 32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, A5, 0, 0, 0, 0);
        chk("a5_ipc", instr_pc, 32'h100);
        chk("a5_instr", instr, A5);
        drive(0, 0, 0, 0, 1, 32'h40, 1);
        chk("trapbr_addr", imem_addr, 32'h100);
        chk("trapbr_iv", instr_valid, 0);

        // PC wrap at the top of the address space.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, A6, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        chk("br_top_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, A7, 0, 0, 0, 0);
        chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
        idle();
        chk("wrap_req", imem_req, 1);
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_fault", fetch_fault, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, A8, 0, 0, 0, 0);
        chk("a8_iv", instr_valid, 1);

        // Reset while holding an instruction.
        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("hrst_req", imem_req, 0);
        chk("hrst_addr", imem_addr, 0);
        chk("hrst_iv", instr_valid, 0);
        chk("hrst_instr", instr, 0);
        chk("hrst_ipc", instr_pc, 0);
        chk("hrst_fault", fetch_fault, 0);
        chk("hrst_pc", pc, 0);
        reset = 1'b0;
        idle();
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
